lut_cluster: RTL
================

# lut_cluster

Parametrised cluster of `NUM_LUTS` lookup tables sharing one word-wide programming port. Each LUT has a configurable optional output register. A small load FSM replaces the single-bit shift chain of the earlier per-LUT design: configuration arrives as `PROG_WIDTH`-bit words over a valid/ready handshake, and `prog_done` signals when the cluster is usable. The cluster is the logic element instantiated per fabric tile.

## Interface
- `LUT_SIZE`, 6, inputs per LUT (K); truth table is 2^K bits
- `NUM_LUTS`, 4, LUTs in cluster
- `PROG_WIDTH`, 8, programming word width
- `clk`  in  1  single clock for programming and user logic
- `rst_n`  in  1  synchronous, active-low reset
- `prog_start`  in  1  pulse; begin (or restart) a configuration load
- `prog_valid`  in  1  `prog_data` valid
- `prog_ready`  out  1  cluster accepts a word this cycle
- `prog_data`  in  PROG_WIDTH  configuration word
- `prog_done`  out  1  level; configuration complete, outputs live
- `lut_in`  in  NUM_LUTS*LUT_SIZE  LUT i uses bits [i*K +: K]
- `lut_out`  out  NUM_LUTS  LUT outputs
- `rb_start`  in  1  readback request (only with `LUT_CFG_READBACK_EN`)
- `rb_valid`  out  1  readback word valid (only with macro)
- `rb_data`  out  PROG_WIDTH  readback word (only with macro)

## Operation
- Config layout: `BITS_PER_LUT` = 2^K+1; LUT i owns bits [i*BITS_PER_LUT +: BITS_PER_LUT]. Within it, bit j < 2^K is the truth-table entry for input value j, and bit 2^K is `reg_en`.
- `CFG_BITS` = NUM_LUTS*BITS_PER_LUT; `NWORDS` = ceil(CFG_BITS/PROG_WIDTH). Word w bit b maps to config bit w*PROG_WIDTH+b. Pad bits beyond `CFG_BITS` are discarded on write and read back as 0.
- FSM states:
  - UNCFG (after reset)
  - LOAD
  - CFG
- `prog_start` in any state: go to LOAD, word counter = 0, clear all output registers. Config memory is not cleared.
- LOAD:
  - `prog_ready`=1.
  - Each accepted word (valid&ready) writes word[counter], then counter++.
  - The accept with counter == NWORDS-1 moves to CFG.
- `prog_ready`=0 in UNCFG and CFG.
- `prog_start` and `prog_valid` in the same LOAD cycle: start wins, the word is dropped, and the counter goes to 0.
- Output path, LUT i, when not in CFG: `lut_out[i]`=0.
- Output path, LUT i, in CFG with `reg_en`=0: `lut_out[i]` = truth[lut_in_i], combinational.
- Output path, LUT i, in CFG with `reg_en`=1: `lut_out[i]` = register that captures truth[lut_in_i] every cycle while in CFG. The register is held at 0 outside CFG.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - state UNCFG, counter 0, config memory all 0, output registers 0
  - `prog_ready`=0, `prog_done`=0, `lut_out`=0, `rb_valid`=0, `rb_data`=0
- Reset during LOAD or readback: abort immediately to the reset values above.
- `prog_ready` rises the cycle after `prog_start` is sampled.
- `prog_done` rises the cycle after the final word is accepted, and stays high until the next `prog_start` or reset. It falls the cycle after `prog_start`.
- Registered LUT latency is 1 cycle from `lut_in` to `lut_out`. The first valid registered output appears 1 cycle after `prog_done` rises.
- Combinational LUTs are valid in the same cycle that `prog_done` is high.

## Configuration
- Macro: `LUT_CFG_READBACK_EN`.
- Defined:
  - `rb_start` sampled high in CFG streams words 0..NWORDS-1 on `rb_data`, starting the next cycle.
  - `rb_valid` is high for exactly NWORDS consecutive cycles; there is no backpressure.
  - `rb_start` while streaming, or outside CFG, is ignored.
  - `prog_start` while streaming aborts it: `rb_valid`=0 the next cycle.
  - Readback does not disturb `lut_out`.
- Undefined: `rb_*` ports and all readback logic are absent. Config storage may then be write-only.

## Structure
- Package `lut_cluster_pkg`:
  - FSM state enum (UNCFG/LOAD/CFG)
  - functions `bits_per_lut(K)`, `cfg_bits(K,N)`, `nwords(K,N,W)`
- Sub-module `lut_cell`: one K-input truth table plus `reg_en` mux and output register, with inputs `cfg[BITS_PER_LUT-1:0]` and `live`. Instantiate it NUM_LUTS times in a generate loop.
- The top level owns the FSM, the word counter (width $clog2(NWORDS)), config storage and readback.

## Test plan
Defaults throughout: K=6, N=4, W=8, giving BITS_PER_LUT=65, CFG_BITS=260, NWORDS=33.
- Reset: hold `rst_n`=0 for 2 cycles with random `lut_in` -> `lut_out`=4'h0, `prog_ready`=0, `prog_done`=0.
- Full load: all 33 words = 8'hFF (so `reg_en`=1 for every LUT) -> `prog_done`=1 one cycle after the 33rd accept; `lut_out`=4'hF one cycle later for any `lut_in`.
- AND6 with registered output: LUT0 config has only bit 63 and bit 64 set, all other LUTs zero; apply `lut_in[5:0]`=6'h3F -> `lut_out[0]`=1 exactly 1 cycle later. Apply 6'h3E -> `lut_out[0]`=0 one cycle later.
- Backpressure/gaps: `prog_valid` toggled randomly (about 50%) -> only accepted words count; `prog_done` asserts after exactly 33 accepts and not earlier.
- Restart mid-load: after 10 words, assert `prog_start` together with `prog_valid` -> that word is dropped and 33 further accepts are required. Also issue `prog_start` in CFG -> `prog_done` falls and `lut_out`=0 the next cycle.
- Readback (macro on): after loading known pattern word[w]=w -> `rb_start` yields `rb_valid` for 33 cycles with `rb_data`=0..31, then 8'h00 for word 32, because config bits 256..259 = 0 and the pad bits read back 0.

Source files
------------

// File: rtl/lut_cluster_pkg.sv
// Shared types and sizing helpers for the LUT cluster.
// Readback logic is built only when LUT_CFG_READBACK_EN is defined.
package lut_cluster_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    CFG   = 2'd2
  } state_e;

  function automatic int bits_per_lut(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int cfg_bits(input int k, input int n);
    return n * bits_per_lut(k);
  endfunction

  function automatic int nwords(input int k, input int n, input int w);
    return (cfg_bits(k, n) + w - 1) / w;
  endfunction

endpackage

// File: rtl/lut_cluster_cell.sv
// One K-input LUT: truth-table lookup, reg_en select and output register.
// The register only tracks the table while the cluster is live.
module lut_cell
  import lut_cluster_pkg::*;
#(
  parameter int K   = 6,
  parameter int BPL = bits_per_lut(K)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           live,
  input  logic [BPL-1:0] cfg,
  input  logic [K-1:0]   lut_in,
  output logic           lut_out
);

  logic truth;
  logic reg_en;
  logic out_q;

  assign truth  = cfg[{1'b0, lut_in}];
  assign reg_en = cfg[BPL-1];

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !live) out_q <= 1'b0;
    else                        out_q <= truth;
  end

  assign lut_out = live & (reg_en ? out_q : truth);

endmodule

// File: rtl/lut_cluster.sv
// LUT cluster: word-wide config load FSM, config storage and NUM_LUTS cells.
// Optional config readback stream under LUT_CFG_READBACK_EN.
module lut_cluster
  import lut_cluster_pkg::*;
#(
  parameter int LUT_SIZE   = 6,
  parameter int NUM_LUTS   = 4,
  parameter int PROG_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prog_start,
  input  logic                         prog_valid,
  output logic                         prog_ready,
  input  logic [PROG_WIDTH-1:0]        prog_data,
  output logic                         prog_done,
  input  logic [NUM_LUTS*LUT_SIZE-1:0] lut_in,
  output logic [NUM_LUTS-1:0]          lut_out
`ifdef LUT_CFG_READBACK_EN
  ,
  input  logic                         rb_start,
  output logic                         rb_valid,
  output logic [PROG_WIDTH-1:0]        rb_data
`endif
);

  localparam int BPL  = bits_per_lut(LUT_SIZE);
  localparam int CFGB = cfg_bits(LUT_SIZE, NUM_LUTS);
  localparam int NW   = nwords(LUT_SIZE, NUM_LUTS, PROG_WIDTH);
  localparam int CW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int TOT  = NW * PROG_WIDTH;

  state_e                             state_q;
  logic [CW-1:0]                      cnt_q;
  logic                               ready_q;
  logic                               done_q;
  logic [NW-1:0][PROG_WIDTH-1:0]      cfg_q;
  logic [TOT-1:0]                     cfg_flat;
  logic [PROG_WIDTH-1:0]              wmask;
  logic                               wr_en;
  logic                               live;

  assign wr_en = !prog_start && (state_q == LOAD) && prog_valid;
  assign live  = (state_q == CFG);

  // Bits of the current word that land beyond CFG_BITS are dropped on write.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < PROG_WIDTH; b++)
      wmask[b] = (int'(cnt_q) * PROG_WIDTH + b) < CFGB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (prog_start) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (prog_valid) begin
            if (cnt_q == CW'(NW - 1)) begin
              state_q <= CFG;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        CFG: begin
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     cfg_q        <= '0;
    else if (wr_en) cfg_q[cnt_q] <= prog_data & wmask;
  end

  assign prog_ready = ready_q;
  assign prog_done  = done_q;
  assign cfg_flat   = cfg_q;

  generate
    if (TOT > CFGB) begin : g_pad
      logic unused_pad;
      assign unused_pad = |cfg_flat[TOT-1:CFGB];
    end
  endgenerate

  for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_lut
    lut_cell #(.K(LUT_SIZE)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (prog_start),
      .live   (live),
      .cfg    (cfg_flat[gi*BPL +: BPL]),
      .lut_in (lut_in[gi*LUT_SIZE +: LUT_SIZE]),
      .lut_out(lut_out[gi])
    );
  end

`ifdef LUT_CFG_READBACK_EN
  logic          rb_valid_q;
  logic [CW-1:0] rb_cnt_q;

  // One word per cycle, no backpressure; a new request is ignored mid-stream.
  always_ff @(posedge clk) begin
    if (!rst_n || prog_start) begin
      rb_valid_q <= 1'b0;
      rb_cnt_q   <= '0;
    end else if (rb_valid_q) begin
      if (rb_cnt_q == CW'(NW - 1)) begin
        rb_valid_q <= 1'b0;
        rb_cnt_q   <= '0;
      end else begin
        rb_cnt_q <= rb_cnt_q + CW'(1);
      end
    end else if (rb_start && state_q == CFG) begin
      rb_valid_q <= 1'b1;
      rb_cnt_q   <= '0;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_valid_q ? cfg_q[rb_cnt_q] : '0;
`endif

endmodule
